// File: rtl/debug_step_ctrl.sv
// debug_step_ctrl: board-level stepping controller for the RV32 core debug port.
// Conditions the step/run buttons (2-FF sync + debounce + rising-edge detect),
// then issues one-cycle debug_step pulses as single steps, a free run at a
// divided rate, or a burst of N steps, and keeps a wrapping count of pulses.
module debug_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RUN_DIV         = 4,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             dbg_mode_sw,
  input  logic [7:0]       burst_len,
  input  logic             burst_go,
  output logic             debug_en,
  output logic             debug_step,
  output logic             busy,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] step_count
);

  localparam int DB_W  = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W = (RUN_DIV < 2) ? 1 : $clog2(RUN_DIV);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_BURST = 2'b10
  } state_t;

  logic            r_step_s1, r_step_s2, r_run_s1, r_run_s2;
  logic [DB_W-1:0] r_step_db, r_run_db;
  logic            r_step_filt, r_run_filt, r_step_filt_d, r_run_filt_d;
  logic            r_dbg_en;
  state_t          r_state;
  logic            r_busy;
  logic            r_step;
  logic [DIV_W-1:0] r_div;
  logic [7:0]      r_remaining;
  logic [CNT_W-1:0] r_count;
  logic            w_step_rise, w_run_rise;

  // Bring the raw buttons into the clock domain with two flops each.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_run_s1  <= 1'b0;
      r_run_s2  <= 1'b0;
    end else begin
      r_step_s1 <= btn_step;
      r_step_s2 <= r_step_s1;
      r_run_s1  <= btn_run;
      r_run_s2  <= r_run_s1;
    end
  end

  // Debounce: the filtered level follows the synced level only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive samples; any agreement clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step_db   <= '0;
      r_step_filt <= 1'b0;
      r_run_db    <= '0;
      r_run_filt  <= 1'b0;
    end else begin
      if (r_step_s2 == r_step_filt) begin
        r_step_db <= '0;
      end else if (r_step_db == DB_LAST) begin
        r_step_db   <= '0;
        r_step_filt <= r_step_s2;
      end else begin
        r_step_db <= r_step_db + DB_W'(1);
      end
      if (r_run_s2 == r_run_filt) begin
        r_run_db <= '0;
      end else if (r_run_db == DB_LAST) begin
        r_run_db   <= '0;
        r_run_filt <= r_run_s2;
      end else begin
        r_run_db <= r_run_db + DB_W'(1);
      end
    end
  end

  // Delayed filtered levels for edge detection, plus the debug_en copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step_filt_d <= 1'b0;
      r_run_filt_d  <= 1'b0;
      r_dbg_en      <= 1'b0;
    end else begin
      r_step_filt_d <= r_step_filt;
      r_run_filt_d  <= r_run_filt;
      r_dbg_en      <= dbg_mode_sw;
    end
  end

  assign w_step_rise = r_step_filt & ~r_step_filt_d;
  assign w_run_rise  = r_run_filt & ~r_run_filt_d;

  // Stepping FSM: decides when to pulse debug_step and counts every pulse.
  // A run_rise in RUN or BURST aborts without a pulse on that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_step      <= 1'b0;
      r_div       <= '0;
      r_remaining <= '0;
      r_count     <= '0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_run_rise) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_div   <= '0;
          end else if (burst_go && (burst_len != 8'd0)) begin
            r_state     <= S_BURST;
            r_busy      <= 1'b1;
            r_div       <= '0;
            r_remaining <= burst_len;
          end else if (w_step_rise) begin
            r_step  <= 1'b1;
            r_count <= r_count + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (w_run_rise) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_div == DIV_LAST) begin
            r_div   <= '0;
            r_step  <= 1'b1;
            r_count <= r_count + CNT_W'(1);
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_BURST: begin
          if (w_run_rise) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_div == DIV_LAST) begin
            r_div       <= '0;
            r_step      <= 1'b1;
            r_count     <= r_count + CNT_W'(1);
            r_remaining <= r_remaining - 8'd1;
            if (r_remaining == 8'd1) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign debug_en   = r_dbg_en;
  assign debug_step = r_step;
  assign busy       = r_busy;
  assign mode       = r_state;
  assign step_count = r_count;

endmodule
